// File: rtl/adder_pipelined.sv
// Pipelined ripple-carry adder: the carry chain is cut into STAGES slices with a
// register bank after each slice; operands are skewed in and sums de-skewed out.
module adder_pipelined #(
   parameter int NUM_BITS = 16,
   parameter int STAGES   = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [NUM_BITS-1:0] a,
   input  logic [NUM_BITS-1:0] b,
   input  logic                carry_in,
   input  logic                signed_mode,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [NUM_BITS-1:0] sum,
   output logic                overflow
);

   localparam int SLICE = NUM_BITS / STAGES;

   logic w_advance;

   // One global enable: the whole pipe moves or the whole pipe holds.
   assign w_advance = !out_valid || out_ready;
   assign in_ready  = w_advance;

   for (genvar k = 0; k < STAGES; k++) begin : g_st
      localparam int LW = (k + 1) * SLICE;

      logic             w_vin;
      logic             w_sgn;
      logic             w_cin;
      logic [SLICE-1:0] w_a_sl;
      logic [SLICE-1:0] w_b_sl;
      logic [SLICE:0]   w_add;
      logic [LW-1:0]    w_sum_nxt;
      logic             r_vld;
      logic [LW-1:0]    r_sum;

      if (k == 0) begin : g_src
         assign w_vin     = in_valid;
         assign w_sgn     = signed_mode;
         assign w_cin     = carry_in;
         assign w_a_sl    = a[SLICE-1:0];
         assign w_b_sl    = b[SLICE-1:0];
         assign w_sum_nxt = w_add[SLICE-1:0];
      end else begin : g_src
         assign w_vin     = g_st[k-1].r_vld;
         assign w_sgn     = g_st[k-1].g_mid.r_sgn;
         assign w_cin     = g_st[k-1].g_mid.r_cry;
         assign w_a_sl    = g_st[k-1].g_mid.r_a_hi[SLICE-1:0];
         assign w_b_sl    = g_st[k-1].g_mid.r_b_hi[SLICE-1:0];
         assign w_sum_nxt = {w_add[SLICE-1:0], g_st[k-1].r_sum};
      end

      assign w_add = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{SLICE{1'b0}}, w_cin};

      // NOTE: clocked state uses non-blocking assignments so every stage samples
      // its predecessor's pre-edge value, independent of block ordering.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_vld <= 1'b0;
            r_sum <= '0;
         end else if (w_advance) begin
            r_vld <= w_vin;
            r_sum <= w_sum_nxt;
         end
      end

      if (k < STAGES - 1) begin : g_mid
         localparam int RW = NUM_BITS - (k + 1) * SLICE;

         logic [RW-1:0] w_a_rest;
         logic [RW-1:0] w_b_rest;
         logic          r_sgn;
         logic          r_cry;
         logic [RW-1:0] r_a_hi;
         logic [RW-1:0] r_b_hi;

         if (k == 0) begin : g_rest
            assign w_a_rest = a[NUM_BITS-1:SLICE];
            assign w_b_rest = b[NUM_BITS-1:SLICE];
         end else begin : g_rest
            assign w_a_rest = g_st[k-1].g_mid.r_a_hi[RW+SLICE-1:SLICE];
            assign w_b_rest = g_st[k-1].g_mid.r_b_hi[RW+SLICE-1:SLICE];
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_sgn  <= 1'b0;
               r_cry  <= 1'b0;
               r_a_hi <= '0;
               r_b_hi <= '0;
            end else if (w_advance) begin
               r_sgn  <= w_sgn;
               r_cry  <= w_add[SLICE];
               r_a_hi <= w_a_rest;
               r_b_hi <= w_b_rest;
            end
         end
      end else begin : g_last
         logic w_c_msb;
         logic w_ovf;
         logic r_ovf;

         // Carry into the MSB recovered from the MSB's own sum bit.
         assign w_c_msb = w_a_sl[SLICE-1] ^ w_b_sl[SLICE-1] ^ w_add[SLICE-1];
         assign w_ovf   = w_sgn ? (w_c_msb ^ w_add[SLICE]) : w_add[SLICE];

         always_ff @(posedge clk or posedge rst) begin
            if (rst)            r_ovf <= 1'b0;
            else if (w_advance) r_ovf <= w_ovf;
         end
      end
   end

   assign out_valid = g_st[STAGES-1].r_vld;
   assign sum       = g_st[STAGES-1].r_sum;
   assign overflow  = g_st[STAGES-1].g_last.r_ovf;

endmodule

// File: tb/tb_adder_pipelined.sv
// Self-checking bench for adder_pipelined: directed table, backpressure, async
// reset mid-stream, and random streaming across four parameter sets.
module tb_adder_pipelined;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        sgn;
      logic [15:0] s;
      logic        o;
   } vec_t;

   typedef struct {
      logic [31:0] s;
      logic        o;
      int          cyc;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic        sgn;
      int          cyc;
   } tx_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic        cin_i;
   logic        sgn_i;
   logic        out_ready0;
   logic        rdy_hi;

   logic        ir0, ov0, of0;
   logic [15:0] s0;
   logic        ir1, ov1, of1;
   logic [7:0]  s1;
   logic        ir2, ov2, of2;
   logic [7:0]  s2;
   logic        ir3, ov3, of3;
   logic [31:0] s3;

   int   total, bad, cyc;
   int   rd1, rd2, rd3;
   bit   lat_chk, sweep, bp_mode;
   bit   bp_pat [4];
   exp_t q0 [$];
   tx_t  txq [$];
   exp_t cur_exp;
   vec_t vecs [12];

   always #5 clk = ~clk;

   adder_pipelined #(.NUM_BITS(16), .STAGES(4)) u_dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0),
      .a(a_i[15:0]), .b(b_i[15:0]), .carry_in(cin_i), .signed_mode(sgn_i),
      .out_valid(ov0), .out_ready(out_ready0), .sum(s0), .overflow(of0));

   adder_pipelined #(.NUM_BITS(8), .STAGES(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
      .a(a_i[7:0]), .b(b_i[7:0]), .carry_in(cin_i), .signed_mode(sgn_i),
      .out_valid(ov1), .out_ready(rdy_hi), .sum(s1), .overflow(of1));

   adder_pipelined #(.NUM_BITS(8), .STAGES(8)) u_dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2),
      .a(a_i[7:0]), .b(b_i[7:0]), .carry_in(cin_i), .signed_mode(sgn_i),
      .out_valid(ov2), .out_ready(rdy_hi), .sum(s2), .overflow(of2));

   adder_pipelined #(.NUM_BITS(32), .STAGES(4)) u_dut3 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir3),
      .a(a_i), .b(b_i), .carry_in(cin_i), .signed_mode(sgn_i),
      .out_valid(ov3), .out_ready(rdy_hi), .sum(s3), .overflow(of3));

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic fail(input string nm);
      total++;
      bad++;
      $display("FAIL %s (cycle %0d)", nm, cyc);
   endtask

   // Golden model: plain wide addition; signed overflow from operand/result signs.
   function automatic logic [32:0] gold(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sgn);
      logic [32:0] full;
      logic [31:0] m;
      logic [31:0] s;
      logic        o;
      m    = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
      full = {1'b0, a & m} + {1'b0, b & m} + {32'h0, cin};
      s    = full[31:0] & m;
      if (sgn) o = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
      else     o = full[w];
      return {o, s};
   endfunction

   task automatic chk_sweep(input string nm, input logic ir, input logic v, input logic [31:0] s,
                            input logic o, input int w, input int st, input int rd_in,
                            output int rd_out);
      logic [32:0] g;
      rd_out = rd_in;
      check({nm, " in_ready"}, 64'(ir), 64'(1));
      if (v) begin
         if (rd_in >= txq.size()) begin
            fail({nm, " unexpected result"});
         end else begin
            g = gold(w, txq[rd_in].a, txq[rd_in].b, txq[rd_in].cin, txq[rd_in].sgn);
            check({nm, " sum"}, 64'(s), 64'(g[31:0]));
            check({nm, " ovf"}, 64'(o), 64'(g[32]));
            check({nm, " latency"}, 64'(cyc + 1 - txq[rd_in].cyc), 64'(st));
            rd_out = rd_in + 1;
         end
      end
   endtask

   // One clock: sample pre-edge handshakes, take the edge, update scoreboard.
   task automatic step(output bit acc);
      exp_t e;
      bit   pop0, stall0, do_tx;
      if (bp_mode) out_ready0 = bp_pat[cyc % 4];
      #1;
      check("in_ready", 64'(ir0), 64'(!ov0 || out_ready0));
      acc    = in_valid && ir0;
      pop0   = ov0 && out_ready0;
      stall0 = ov0 && !out_ready0;
      if (pop0) begin
         if (q0.size() == 0) begin
            fail("dut0 unexpected result");
         end else begin
            e = q0.pop_front();
            check("dut0 sum", 64'(s0), 64'(e.s[15:0]));
            check("dut0 ovf", 64'(of0), 64'(e.o));
            if (lat_chk) check("dut0 latency", 64'(cyc + 1 - e.cyc), 64'(4));
         end
      end
      do_tx = 1'b0;
      if (sweep) begin
         chk_sweep("n8s1", ir1, ov1, {24'h0, s1}, of1, 8, 1, rd1, rd1);
         chk_sweep("n8s8", ir2, ov2, {24'h0, s2}, of2, 8, 8, rd2, rd2);
         chk_sweep("n32s4", ir3, ov3, s3, of3, 32, 4, rd3, rd3);
         do_tx = in_valid;
      end
      @(posedge clk);
      cyc++;
      if (acc) begin
         e     = cur_exp;
         e.cyc = cyc;
         q0.push_back(e);
      end
      if (do_tx) txq.push_back('{a_i, b_i, cin_i, sgn_i, cyc});
      #1;
      if (stall0) begin
         check("stall out_valid", 64'(ov0), 64'(1));
         if (q0.size() > 0) begin
            check("stall sum", 64'(s0), 64'(q0[0].s[15:0]));
            check("stall ovf", 64'(of0), 64'(q0[0].o));
         end
      end
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic sgn, input logic [15:0] es, input logic eo, output int waits);
      bit acc;
      in_valid = 1'b1;
      a_i      = a;
      b_i      = b;
      cin_i    = cin;
      sgn_i    = sgn;
      cur_exp  = '{{16'h0, es}, eo, 0};
      waits    = 0;
      acc      = 1'b0;
      while (!acc && waits < 50) begin
         step(acc);
         waits++;
      end
      if (!acc) fail("accept timeout");
      in_valid = 1'b0;
   endtask

   task automatic send_rand(output int waits);
      logic [31:0] a, b;
      logic        c, s;
      logic [32:0] g;
      a = $urandom;
      b = $urandom;
      c = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      g = gold(16, a, b, c, s);
      drive(a, b, c, s, g[15:0], g[32], waits);
   endtask

   task automatic drain();
      bit acc;
      int n;
      in_valid = 1'b0;
      n = 0;
      while ((q0.size() > 0 || (sweep && (rd1 < txq.size() || rd2 < txq.size() ||
              rd3 < txq.size()))) && n < 100) begin
         step(acc);
         n++;
      end
      if (n >= 100) fail("drain timeout");
      repeat (3) step(acc);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      bit acc;
      int w;
      vecs[0]  = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0};
      vecs[1]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1};
      vecs[2]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1};
      vecs[3]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0};
      vecs[4]  = '{16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0000, 1'b1};
      vecs[5]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1};
      vecs[6]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b0};
      vecs[7]  = '{16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0};
      vecs[8]  = '{16'h0FFF, 16'h0000, 1'b1, 1'b1, 16'h1000, 1'b0};
      vecs[9]  = '{16'h7FFE, 16'h0000, 1'b1, 1'b1, 16'h7FFF, 1'b0};
      vecs[10] = '{16'h8000, 16'hFFFF, 1'b1, 1'b1, 16'h8000, 1'b0};
      vecs[11] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1};
      bp_pat   = '{1'b1, 1'b0, 1'b0, 1'b1};

      total = 0; bad = 0; cyc = 0;
      rd1 = 0; rd2 = 0; rd3 = 0;
      lat_chk = 1'b0; sweep = 1'b0; bp_mode = 1'b0;
      in_valid = 1'b0; a_i = '0; b_i = '0; cin_i = 1'b0; sgn_i = 1'b0;
      out_ready0 = 1'b1; rdy_hi = 1'b1;

      // Reset state
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset out_valid", 64'(ov0), 64'(0));
      check("reset sum", 64'(s0), 64'(0));
      check("reset ovf", 64'(of0), 64'(0));
      check("reset in_ready", 64'(ir0), 64'(1));
      check("reset valid n8s8", 64'(ov2), 64'(0));
      check("reset valid n32s4", 64'(ov3), 64'(0));
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Basic transaction alone, then the rest of the table back to back
      lat_chk = 1'b1;
      drive({16'h0, vecs[0].a}, {16'h0, vecs[0].b}, vecs[0].cin, vecs[0].sgn,
            vecs[0].s, vecs[0].o, w);
      drain();
      for (int i = 1; i < 12; i++) begin
         drive({16'h0, vecs[i].a}, {16'h0, vecs[i].b}, vecs[i].cin, vecs[i].sgn,
               vecs[i].s, vecs[i].o, w);
         check("table throughput", 64'(w), 64'(1));
      end
      drain();

      // Backpressure with out_ready cycling 1-0-0-1
      lat_chk = 1'b0;
      bp_mode = 1'b1;
      for (int i = 0; i < 6; i++) send_rand(w);
      drain();
      bp_mode    = 1'b0;
      out_ready0 = 1'b1;

      // Async reset with three transactions in flight
      for (int i = 0; i < 3; i++) send_rand(w);
      out_ready0 = 1'b0;
      step(acc);
      check("pre-reset out_valid", 64'(ov0), 64'(1));
      #2;
      rst = 1'b1;
      #1;
      check("async reset out_valid", 64'(ov0), 64'(0));
      check("async reset in_ready", 64'(ir0), 64'(1));
      check("async reset sum", 64'(s0), 64'(0));
      #2;
      rst = 1'b0;
      q0.delete();
      out_ready0 = 1'b1;
      @(posedge clk);
      #1;
      repeat (5) step(acc);
      lat_chk = 1'b1;
      drive(32'h1, 32'h1, 1'b0, 1'b0, 16'h0002, 1'b0, w);
      drain();

      // Random streaming on all four parameter sets
      rst = 1'b1;
      #4;
      rst = 1'b0;
      @(posedge clk);
      #1;
      txq.delete();
      rd1 = 0; rd2 = 0; rd3 = 0;
      sweep = 1'b1;
      for (int i = 0; i < 20; i++) begin
         send_rand(w);
         check("stream throughput", 64'(w), 64'(1));
      end
      drain();
      check("n8s1 count", 64'(rd1), 64'(20));
      check("n8s8 count", 64'(rd2), 64'(20));
      check("n32s4 count", 64'(rd3), 64'(20));
      sweep = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
